// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - decode fields and control word between controller and datapath
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7;
  logic       zero;
  logic       PCWriteEn;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, func3, func7, zero,
    output PCWriteEn, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal_op
  );

  modport slave (
    output op, func3, func7, zero,
    input  PCWriteEn, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM driving datapath enables and selects
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMREAD,
    MEMWB, MEMWRITE, BRANCH, JALR, JUMP, LUI
  } state_t;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       done;
  } ctrl_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [6:0] op;
  logic [2:0] func3;
  logic       func7;
  logic       zero;

  assign op    = bus.op;
  assign func3 = bus.func3;
  assign func7 = bus.func7;
  assign zero  = bus.zero;

  state_t state, nxt;
  ctrl_t  ctrl_q, ctrl_nxt;
  logic   illegal_q;
  logic   legal;
  logic   alu_f3_ok;
  logic   in_decode, in_branch, br_take;

  function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_sel = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_sel = ALU_AND;
      3'b110:  alu_sel = ALU_OR;
      3'b010:  alu_sel = ALU_SLT;
      3'b100:  alu_sel = ALU_XOR;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    alu_f3_ok = (func3 == 3'b000) || (func3 == 3'b111) || (func3 == 3'b110) ||
                (func3 == 3'b010) || (func3 == 3'b100);
    case (op)
      OP_R, OP_I:      legal = alu_f3_ok;
      OP_LW, OP_SW:    legal = (func3 == 3'b010);
      OP_BR:           legal = (func3 == 3'b000) || (func3 == 3'b001) ||
                               (func3 == 3'b100) || (func3 == 3'b101);
      OP_JALR:         legal = (func3 == 3'b000);
      OP_JAL, OP_LUI:  legal = 1'b1;
      default:         legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = FETCH;
      FETCH:    nxt = DECODE;
      DECODE: begin
        if (!legal) nxt = FETCH;
        else begin
          case (op)
            OP_R:         nxt = EXECR;
            OP_I:         nxt = EXECI;
            OP_LW, OP_SW: nxt = MEMADR;
            OP_BR:        nxt = BRANCH;
            OP_JAL:       nxt = JUMP;
            OP_JALR:      nxt = JALR;
            default:      nxt = LUI;
          endcase
        end
      end
      EXECR, EXECI:                    nxt = ALUWB;
      MEMADR:                          nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:                         nxt = MEMWB;
      JALR:                            nxt = JUMP;
      JUMP:                            nxt = ALUWB;
      ALUWB, MEMWB, MEMWRITE, BRANCH, LUI: nxt = FETCH;
      default:                         nxt = IDLE;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops.
  always_comb begin
    ctrl_nxt = '0;
    case (nxt)
      FETCH: begin
        ctrl_nxt.irw = 1'b1;
        ctrl_nxt.pcw = 1'b1;
        ctrl_nxt.sb  = 2'b10;
        ctrl_nxt.rs  = 2'b10;
      end
      DECODE: begin
        ctrl_nxt.sa = 2'b01;
        ctrl_nxt.sb = 2'b01;
      end
      EXECR: begin
        ctrl_nxt.sa  = 2'b10;
        ctrl_nxt.alu = alu_sel(func3, func7);
      end
      EXECI: begin
        ctrl_nxt.sa  = 2'b10;
        ctrl_nxt.sb  = 2'b01;
        ctrl_nxt.imm = IMM_I;
        ctrl_nxt.alu = alu_sel(func3, 1'b0);
      end
      ALUWB, MEMWB: begin
        ctrl_nxt.rw   = 1'b1;
        ctrl_nxt.done = 1'b1;
        ctrl_nxt.rs   = (nxt == MEMWB) ? 2'b01 : 2'b00;
      end
      MEMADR: begin
        ctrl_nxt.sa  = 2'b10;
        ctrl_nxt.sb  = 2'b01;
        ctrl_nxt.imm = (op == OP_SW) ? IMM_S : IMM_I;
      end
      MEMREAD:  ctrl_nxt.adr = 1'b1;
      MEMWRITE: begin
        ctrl_nxt.adr  = 1'b1;
        ctrl_nxt.mw   = 1'b1;
        ctrl_nxt.done = 1'b1;
      end
      BRANCH: begin
        ctrl_nxt.sa   = 2'b10;
        ctrl_nxt.done = 1'b1;
        ctrl_nxt.alu  = func3[2] ? ALU_SLT : ALU_SUB;
      end
      JALR: begin
        ctrl_nxt.sa  = 2'b10;
        ctrl_nxt.sb  = 2'b01;
        ctrl_nxt.imm = IMM_I;
      end
      JUMP: begin
        ctrl_nxt.pcw = 1'b1;
        ctrl_nxt.sa  = 2'b01;
        ctrl_nxt.sb  = 2'b10;
      end
      LUI: begin
        ctrl_nxt.imm  = IMM_U;
        ctrl_nxt.rs   = 2'b11;
        ctrl_nxt.rw   = 1'b1;
        ctrl_nxt.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_nxt;
      if (state == DECODE && !legal) illegal_q <= 1'b1;
    end
  end

  // op is only valid once IR has loaded, so the DECODE-cycle terms are decoded live.
  assign in_decode = (state == DECODE);
  assign in_branch = (state == BRANCH);
  assign br_take   = zero ^ (func3[2] ^ func3[0]);

  assign bus.PCWriteEn  = ctrl_q.pcw | (in_branch & br_take);
  assign bus.AdrSrc     = ctrl_q.adr;
  assign bus.MemWrite   = ctrl_q.mw;
  assign bus.IRWrite    = ctrl_q.irw;
  assign bus.RegWrite   = ctrl_q.rw;
  assign bus.ResultSrc  = ctrl_q.rs;
  assign bus.ALUSrcA    = ctrl_q.sa;
  assign bus.ALUSrcB    = ctrl_q.sb;
  assign bus.ALUControl = ctrl_q.alu;
  assign bus.ImmSrc     = in_decode ? ((op == OP_JAL) ? IMM_J : IMM_B) : ctrl_q.imm;
  assign bus.instr_done = ctrl_q.done | (in_decode & ~legal);
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller state sequencing and control words
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_cmp = 0;
  int   n_err = 0;
  logic ill   = 1'b0;

  // {PCWriteEn,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,instr_done,illegal_op}
  logic [18:0] obs_w;
  assign obs_w = {bus.PCWriteEn, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                  bus.instr_done, bus.illegal_op};

  function automatic logic [18:0] cw(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] alu, imm,
                                     input logic done, il);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, done, il};
  endfunction

  function automatic logic [18:0] w_fetch();       return cw(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,ill); endfunction
  function automatic logic [18:0] w_decode(input logic [2:0] imm); return cw(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,ill); endfunction
  function automatic logic [18:0] w_execr(input logic [2:0] alu);  return cw(0,0,0,0,0,2'b00,2'b10,2'b00,alu,3'b000,0,ill); endfunction
  function automatic logic [18:0] w_execi(input logic [2:0] alu);  return cw(0,0,0,0,0,2'b00,2'b10,2'b01,alu,3'b000,0,ill); endfunction
  function automatic logic [18:0] w_aluwb();       return cw(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,1,ill); endfunction
  function automatic logic [18:0] w_memadr(input logic [2:0] imm); return cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,imm,0,ill); endfunction
  function automatic logic [18:0] w_memread();     return cw(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,ill); endfunction
  function automatic logic [18:0] w_memwb();       return cw(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,1,ill); endfunction
  function automatic logic [18:0] w_memwrite();    return cw(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,ill); endfunction
  function automatic logic [18:0] w_branch(input logic pcw, input logic [2:0] alu); return cw(pcw,0,0,0,0,2'b00,2'b10,2'b00,alu,3'b000,1,ill); endfunction
  function automatic logic [18:0] w_jump();        return cw(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0,ill); endfunction
  function automatic logic [18:0] w_jalr();        return cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,ill); endfunction
  function automatic logic [18:0] w_lui();         return cw(0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,3'b100,1,ill); endfunction
  function automatic logic [18:0] w_bad();         return cw(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,1,ill); endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    n_cmp++;
    assert (obs_w === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs_w, exp);
    end
  endtask

  task automatic nxt(input string tag, input logic [18:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    bus.op    = o;
    bus.func3 = f3;
    bus.func7 = f7;
  endtask

  initial begin
    bus.zero = 1'b0;
    set_ins(7'b0110011, 3'b000, 1'b1);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", '0);
    rst = 1'b1;
    chk("idle", '0);

    // sub
    nxt("r_fetch", w_fetch());
    nxt("r_decode", w_decode(3'b010));
    nxt("r_execr_sub", w_execr(3'b001));
    nxt("r_aluwb", w_aluwb());
    set_ins(7'b0000011, 3'b010, 1'b0);

    // lw
    nxt("lw_fetch", w_fetch());
    nxt("lw_decode", w_decode(3'b010));
    nxt("lw_memadr", w_memadr(3'b000));
    nxt("lw_memread", w_memread());
    nxt("lw_memwb", w_memwb());
    set_ins(7'b0100011, 3'b010, 1'b0);

    // sw
    nxt("sw_fetch", w_fetch());
    nxt("sw_decode", w_decode(3'b010));
    nxt("sw_memadr", w_memadr(3'b001));
    nxt("sw_memwrite", w_memwrite());
    set_ins(7'b1100011, 3'b000, 1'b0);
    bus.zero = 1'b1;

    // beq, zero toggled within BRANCH; zero=1 during FETCH must not matter
    nxt("beq_fetch", w_fetch());
    nxt("beq_decode", w_decode(3'b010));
    nxt("beq_z1", w_branch(1'b1, 3'b001));
    bus.zero = 1'b0;
    #1 chk("beq_z0", w_branch(1'b0, 3'b001));
    set_ins(7'b1100011, 3'b100, 1'b0);

    // blt
    nxt("blt_fetch", w_fetch());
    nxt("blt_decode", w_decode(3'b010));
    nxt("blt_z0", w_branch(1'b1, 3'b100));
    bus.zero = 1'b1;
    #1 chk("blt_z1", w_branch(1'b0, 3'b100));
    set_ins(7'b1100011, 3'b101, 1'b0);

    // bge with zero=1 takes
    nxt("bge_fetch", w_fetch());
    nxt("bge_decode", w_decode(3'b010));
    nxt("bge_z1", w_branch(1'b1, 3'b100));
    bus.zero = 1'b0;
    set_ins(7'b1101111, 3'b000, 1'b0);

    // jal
    nxt("jal_fetch", w_fetch());
    nxt("jal_decode", w_decode(3'b011));
    nxt("jal_jump", w_jump());
    nxt("jal_aluwb", w_aluwb());
    set_ins(7'b1100111, 3'b000, 1'b0);

    // jalr
    nxt("jalr_fetch", w_fetch());
    nxt("jalr_decode", w_decode(3'b010));
    nxt("jalr_jalr", w_jalr());
    nxt("jalr_jump", w_jump());
    nxt("jalr_aluwb", w_aluwb());
    set_ins(7'b0110111, 3'b000, 1'b0);

    // lui
    nxt("lui_fetch", w_fetch());
    nxt("lui_decode", w_decode(3'b010));
    nxt("lui_lui", w_lui());
    set_ins(7'b0010011, 3'b000, 1'b1);

    // addi: func7 ignored
    nxt("addi_fetch", w_fetch());
    nxt("addi_decode", w_decode(3'b010));
    nxt("addi_execi", w_execi(3'b000));
    nxt("addi_aluwb", w_aluwb());
    set_ins(7'b1111111, 3'b000, 1'b0);

    // illegal opcode
    nxt("bad_fetch", w_fetch());
    nxt("bad_decode", w_bad());
    ill = 1'b1;
    nxt("bad_refetch", w_fetch());
    set_ins(7'b0110011, 3'b110, 1'b0);
    nxt("or_decode", w_decode(3'b010));
    nxt("or_execr", w_execr(3'b011));
    nxt("or_aluwb", w_aluwb());
    set_ins(7'b0110011, 3'b100, 1'b0);
    nxt("xor_fetch", w_fetch());
    nxt("xor_decode", w_decode(3'b010));
    nxt("xor_execr", w_execr(3'b101));

    // reset mid-instruction clears everything including illegal_op
    rst = 1'b0;
    ill = 1'b0;
    #1 chk("rst_mid", '0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_idle", '0);
    set_ins(7'b0100011, 3'b010, 1'b0);

    // reset during MEMWRITE
    nxt("sw2_fetch", w_fetch());
    nxt("sw2_decode", w_decode(3'b010));
    nxt("sw2_memadr", w_memadr(3'b001));
    nxt("sw2_memwrite", w_memwrite());
    rst = 1'b0;
    #1 chk("sw2_rst", '0);
    @(negedge clk);
    rst = 1'b1;
    chk("sw2_idle", '0);
    set_ins(7'b0000011, 3'b000, 1'b0);

    // lw with illegal func3
    nxt("lwbad_fetch", w_fetch());
    nxt("lwbad_decode", w_bad());
    ill = 1'b1;
    nxt("lwbad_refetch", w_fetch());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
